vx_smem_responder: RTL and testbench



---
 rtl/vx_smem_responder.sv | 192 +++++++++++++++++++
 tb/tb_vx_smem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_smem_responder.sv
// Banked scratchpad that acts as the slave end of the LSU per-lane core request/response interface.
// Optional perf counters are enabled by defining SMEM_PERF_EN.
module vx_smem_lane #(
  parameter int NUM_BANKS = 4,
  parameter int BW        = 2
) (
  input  logic [NUM_BANKS-1:0][31:0] bank_rdata,
  input  logic [BW-1:0]              sel,
  output logic [31:0]                data
);
  assign data = bank_rdata[sel];
endmodule

module vx_smem_responder #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int SIZE      = 4096,
  parameter int TAG_WIDTH = 8,
  parameter int RSPQ_SIZE = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0]                req_rw,
  input  logic [NUM_REQS-1:0][29:0]          req_addr,
  input  logic [NUM_REQS-1:0][3:0]           req_byteen,
  input  logic [NUM_REQS-1:0][31:0]          req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic [NUM_REQS-1:0]                rsp_valid,
  output logic [NUM_REQS-1:0][31:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  input  logic                               rsp_ready
`ifdef SMEM_PERF_EN
  ,
  output logic [31:0]                        perf_reads,
  output logic [31:0]                        perf_writes,
  output logic [31:0]                        perf_conflicts
`endif
);
  localparam int BW   = $clog2(NUM_BANKS);
  localparam int ROWS = SIZE / NUM_BANKS;
  localparam int RW   = $clog2(ROWS);
  localparam int LW   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PW   = $clog2(RSPQ_SIZE);
  localparam int CW   = $clog2(RSPQ_SIZE + 1);

  logic [NUM_REQS-1:0][BW-1:0] lane_bank;
  logic [NUM_REQS-1:0][RW-1:0] lane_row;
  logic [NUM_REQS-1:0]         unused_addr;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_dec
    assign lane_bank[i]   = req_addr[i][BW-1:0];
    assign lane_row[i]    = req_addr[i][BW +: RW];
    assign unused_addr[i] = ^req_addr[i][29:BW+RW];
  end

  // Arbitration: lowest valid lane owns its bank; same-row reads ride along
  logic [NUM_BANKS-1:0]         win_found;
  logic [NUM_BANKS-1:0][LW-1:0] win_lane;
  logic [NUM_REQS-1:0]          granted;
  logic                         credit_ok;
  logic                         s1_valid;
  logic [CW-1:0]                q_count;

  always_comb begin
    logic [LW-1:0] w;
    win_found = '0;
    win_lane  = '0;
    granted   = '0;
    w         = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found[lane_bank[i]] = 1'b1;
        win_lane[lane_bank[i]]  = LW'(i);
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      w = win_lane[lane_bank[i]];
      granted[i] = req_valid[i] && ((w == LW'(i)) ||
                   (!req_rw[i] && !req_rw[w] && (lane_row[i] == lane_row[w])));
    end
  end

  assign credit_ok = (32'(q_count) + 32'(s1_valid)) < RSPQ_SIZE;
  assign req_ready = granted & (req_rw | {NUM_REQS{credit_ok}});

  logic [NUM_REQS-1:0] fire, rd_fire;
  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_rw;

  // Banks: byte-enabled write and registered read, driven by the bank winner
  logic [NUM_BANKS-1:0][31:0] bank_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0]   mem [ROWS];
    logic [31:0]   rdata;
    logic [LW-1:0] w;
    logic          we, re;
    assign w  = win_lane[b];
    assign we = win_found[b] && req_rw[w];
    assign re = win_found[b] && !req_rw[w] && credit_ok;
    always_ff @(posedge clk) begin
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (req_byteen[w][k]) mem[lane_row[w]][8*k +: 8] <= req_data[w][8*k +: 8];
      end
      if (re) rdata <= mem[lane_row[w]];
    end
    assign bank_rdata[b] = rdata;
  end

  // Stage 1
  logic [NUM_REQS-1:0]         s1_mask;
  logic [NUM_REQS-1:0][BW-1:0] s1_bank;
  logic [TAG_WIDTH-1:0]        s1_tag, rd_tag;
  logic [NUM_REQS-1:0][31:0]   s1_data;

  always_comb begin
    rd_tag = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--)
      if (rd_fire[i]) rd_tag = req_tag[i];
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= |rd_fire;
  end

  always_ff @(posedge clk) begin
    s1_mask <= rd_fire;
    s1_bank <= lane_bank;
    s1_tag  <= rd_tag;
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    vx_smem_lane #(.NUM_BANKS(NUM_BANKS), .BW(BW)) u_lane (
      .bank_rdata (bank_rdata),
      .sel        (s1_bank[i]),
      .data       (s1_data[i])
    );
  end

  // Response queue; credit accounting guarantees a push always has room
  logic [NUM_REQS-1:0]       q_mask [RSPQ_SIZE];
  logic [NUM_REQS-1:0][31:0] q_data [RSPQ_SIZE];
  logic [TAG_WIDTH-1:0]      q_tag  [RSPQ_SIZE];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic                      push, pop;

  assign push = s1_valid;
  assign pop  = (q_count != '0) && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSPQ_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSPQ_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mask[wr_ptr] <= s1_mask;
      q_data[wr_ptr] <= s1_data;
      q_tag[wr_ptr]  <= s1_tag;
    end
  end

  assign rsp_valid = (q_count != '0) ? q_mask[rd_ptr] : '0;
  assign rsp_data  = q_data[rd_ptr];
  assign rsp_tag   = q_tag[rd_ptr];

`ifdef SMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads     <= '0;
      perf_writes    <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_reads     <= perf_reads + 32'($countones(rd_fire));
      perf_writes    <= perf_writes + 32'($countones(fire & req_rw));
      perf_conflicts <= perf_conflicts + 32'($countones(req_valid & ~req_ready));
    end
  end
`endif

endmodule

// File: tb/tb_vx_smem_responder.sv
// Bench for vx_smem_responder: arbitration vector table plus a scoreboard fed by a word-memory model.
module tb_vx_smem_responder;
  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            req_valid, req_rw, req_ready, rsp_valid;
  logic [3:0][29:0]      req_addr;
  logic [3:0][3:0]       req_byteen;
  logic [3:0][31:0]      req_data, rsp_data;
  logic [3:0][7:0]       req_tag;
  logic [7:0]            rsp_tag;
  logic                  rsp_ready;
`ifdef SMEM_PERF_EN
  logic [31:0]           perf_reads, perf_writes, perf_conflicts;
`endif

  always #5 clk = ~clk;

  vx_smem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
`ifdef SMEM_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_conflicts(perf_conflicts)
`endif
  );

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][31:0] data;
    logic [7:0]       tag;
  } beat_t;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       rw;
    logic [3:0][29:0] addr;
    logic [7:0]       tag;
    logic [3:0]       exp_ready;
  } vec_t;

  beat_t       sb[$];
  logic [31:0] mem_m [int];
  logic [3:0]  last_fire;
  int          n_chk = 0, n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic idle();
    req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
  endtask

  task automatic set_lane(int i, logic rw, logic [29:0] a, logic [3:0] be, logic [31:0] d, logic [7:0] t);
    req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a;
    req_byteen[i] = be; req_data[i] = d; req_tag[i] = t;
  endtask

  // Observe the cycle's handshakes, then advance to the next negedge
  task automatic observe();
    beat_t      b;
    logic [3:0] f;
    int         lo;
    f = req_valid & req_ready;
    last_fire = f;
    if (reset) return;
    if (rsp_valid != 4'b0 && rsp_ready) begin
      if (sb.size() == 0) check("sb_unexpected_beat", 32'(rsp_valid), 32'h0);
      else begin
        b = sb.pop_front();
        check("rsp_mask", 32'(rsp_valid), 32'(b.mask));
        check("rsp_tag", 32'(rsp_tag), 32'(b.tag));
        for (int i = 0; i < 4; i++)
          if (b.mask[i]) check($sformatf("rsp_data[%0d]", i), rsp_data[i], b.data[i]);
      end
    end
    if ((f & ~req_rw) != 4'b0) begin
      b.mask = f & ~req_rw; b.data = '0; lo = -1;
      for (int i = 0; i < 4; i++)
        if (b.mask[i]) begin
          b.data[i] = mem_m[int'(req_addr[i][11:0])];
          if (lo < 0) lo = i;
        end
      b.tag = req_tag[lo];
      sb.push_back(b);
    end
    for (int i = 0; i < 4; i++)
      if (f[i] && req_rw[i]) begin
        logic [31:0] w;
        w = mem_m.exists(int'(req_addr[i][11:0])) ? mem_m[int'(req_addr[i][11:0])] : 32'h0;
        for (int k = 0; k < 4; k++) if (req_byteen[i][k]) w[8*k +: 8] = req_data[i][8*k +: 8];
        mem_m[int'(req_addr[i][11:0])] = w;
      end
  endtask

  task automatic tick();
    #1 observe();
    @(negedge clk);
  endtask

  task automatic wr(logic [29:0] a, logic [31:0] d, logic [3:0] be);
    idle(); set_lane(0, 1'b1, a, be, d, 8'h0); tick(); idle();
  endtask

  task automatic drain(string name);
    idle();
    for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    check(name, 32'(sb.size()), 32'h0);
  endtask

  vec_t tbl[8];
  int   acc;

  initial begin
    // Arbitration vectors; every address read here is preloaded first
    tbl[0] = '{4'b1111, 4'b0000, '{30'h1, 30'h8, 30'h4, 30'h0}, 8'h11, 4'b1001};
    tbl[1] = '{4'b1111, 4'b0000, '{30'h40, 30'h40, 30'h40, 30'h40}, 8'h07, 4'b1111};
    tbl[2] = '{4'b0011, 4'b0011, '{30'h0, 30'h0, 30'h40, 30'h40}, 8'h12, 4'b0001};
    tbl[3] = '{4'b0011, 4'b0001, '{30'h0, 30'h0, 30'h48, 30'h48}, 8'h13, 4'b0001};
    tbl[4] = '{4'b1111, 4'b1000, '{30'h41, 30'h40, 30'h44, 30'h40}, 8'h14, 4'b1101};
    tbl[5] = '{4'b1110, 4'b1000, '{30'h3, 30'h2, 30'h2, 30'h0}, 8'h15, 4'b1110};
    tbl[6] = '{4'b0011, 4'b0010, '{30'h0, 30'h0, 30'h4C, 30'h4C}, 8'h16, 4'b0001};
    tbl[7] = '{4'b1111, 4'b0000, '{30'h53, 30'h52, 30'h51, 30'h4050}, 8'h17, 4'b1111};

    idle(); rsp_ready = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
`ifdef SMEM_PERF_EN
    check("reset_perf_reads", perf_reads, 32'h0);
`endif
    @(negedge clk);

    for (int a = 0; a < 'h60; a++) wr(30'(a), {16'hBE00 ^ 16'(a), 16'(a * 7)}, 4'hF);

    // Write then read back with T+2 latency
    wr(30'h10, 32'hDEADBEEF, 4'hF);
    set_lane(0, 1'b0, 30'h10, 4'h0, 32'h0, 8'h03); tick(); idle();
    #1 check("lat_t1_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    #1 check("lat_t2_rsp_valid", 32'(rsp_valid), 32'h1);
    check("lat_t2_rsp_data", rsp_data[0], 32'hDEADBEEF);
    check("lat_t2_rsp_tag", 32'(rsp_tag), 32'h3);
    tick();

    // Byte enables
    wr(30'h20, 32'h11223344, 4'hF);
    wr(30'h20, 32'hAABBCCDD, 4'h5);
    set_lane(0, 1'b0, 30'h20, 4'h0, 32'h0, 8'h04); tick(); idle(); tick();
    #1 check("byteen_data", rsp_data[0], 32'h11BB33DD);
    tick();
    drain("drain_basic");

    // Table-driven arbitration
    for (int r = 0; r < 8; r++) begin
      idle();
      for (int i = 0; i < 4; i++)
        if (tbl[r].valid[i])
          set_lane(i, tbl[r].rw[i], tbl[r].addr[i], 4'hF, 32'hC0DE0000 + 32'(r * 16 + i), tbl[r].tag);
      #1 check($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
      tick(); idle(); tick();
    end
    drain("drain_tbl");

    // Bank conflict with held lanes resolving over successive cycles
    idle();
    set_lane(0, 1'b0, 30'h0, 4'h0, 32'h0, 8'h21);
    set_lane(1, 1'b0, 30'h4, 4'h0, 32'h0, 8'h21);
    set_lane(2, 1'b0, 30'h8, 4'h0, 32'h0, 8'h21);
    set_lane(3, 1'b0, 30'h1, 4'h0, 32'h0, 8'h21);
    #1 check("conf_c1_ready", 32'(req_ready), 32'b1001);
    tick(); req_valid &= ~last_fire;
    #1 check("conf_c2_ready", 32'(req_ready), 32'b0010);
    tick(); req_valid &= ~last_fire;
    #1 check("conf_c3_ready", 32'(req_ready), 32'b0100);
    tick();
    drain("drain_conflict");

    // Back-pressure: exactly RSPQ_SIZE reads accepted, writes still flow
    rsp_ready = 1'b0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      idle(); set_lane(0, 1'b0, 30'h30 + 30'(acc), 4'h0, 32'h0, 8'h20 + 8'(acc));
      tick();
      if (last_fire[0]) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd4);
    idle(); set_lane(0, 1'b0, 30'h30, 4'h0, 32'h0, 8'h99);
    #1 check("bp_read_blocked", 32'(req_ready), 32'h0);
    @(negedge clk);
    idle(); set_lane(0, 1'b1, 30'h58, 4'hF, 32'h600DF00D, 8'h0);
    #1 check("bp_write_ok", 32'(req_ready), 32'h1);
    tick();
    rsp_ready = 1'b1;
    drain("drain_bp");

    // Reset mid-flight: two queued, one in stage 1
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle(); set_lane(0, 1'b0, 30'h11 + 30'(c), 4'h0, 32'h0, 8'h31 + 8'(c)); tick();
    end
    idle();
    #1 check("mid_pre_rsp_valid", 32'(rsp_valid), 32'h1);
    reset = 1'b1; sb.delete();
    tick();
    reset = 1'b0;
    #1 check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
`ifdef SMEM_PERF_EN
    check("mid_perf_reads", perf_reads, 32'h0);
    check("mid_perf_writes", perf_writes, 32'h0);
    check("mid_perf_conflicts", perf_conflicts, 32'h0);
`endif
    tick();
    #1 check("mid_s1_dropped", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b1;
    set_lane(0, 1'b0, 30'h10, 4'h0, 32'h0, 8'h40); tick(); idle(); tick();
    #1 check("mid_mem_kept", rsp_data[0], 32'hDEADBEEF);
    tick();
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
